layernorm_sched: RTL and testbench

- Round-robin scheduler that shares one layernorm engine between N_REQ requesters (e.g. per-head or per-token-row producers).
- Accepts a request, steers the engine's operand mux and pulses its start, then waits for the engine's valid.
- Returns a tagged response, holding it under backpressure.
- Includes a watchdog so a hung engine cannot deadlock the requesters.

---
 rtl/layernorm_ctrl_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/layernorm_sched.sv | 138 +++++++++++++
 tb/tb_layernorm_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layernorm_ctrl_pkg.sv
// Shared types and helpers for the layernorm scheduler.
// The same types are meant for reuse by other shared-engine schedulers.
package layernorm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int N_REQ_DEF   = 4;
    localparam int TAG_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;
    typedef logic [TAG_W_DEF-1:0]         tag_t;

    function automatic int wd_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    localparam int WD_W_DEF = wd_width(TIMEOUT_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap.
// Produces a one-hot grant, its encoded index and an any-grant flag.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int c;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int i = 1; i <= N; i++) begin
            c = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/layernorm_sched.sv
// Round-robin scheduler sharing one layernorm engine between requesters,
// with a tagged, backpressured response path and a sticky watchdog.
module layernorm_sched
    import layernorm_ctrl_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int TAG_W   = 4,
    parameter  int TIMEOUT = 64,
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*TAG_W-1:0] req_tag,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   eng_start,
    output logic [ID_W-1:0]        eng_sel,
    input  logic                   eng_done,
    output logic                   resp_valid,
    output logic [ID_W-1:0]        resp_id,
    output logic [TAG_W-1:0]       resp_tag,
    input  logic                   resp_ready,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   err_clr
);

    localparam int WD_W = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic [TAG_W-1:0]   tag_sel;
    logic               accept;
    logic               wd_max;
    logic               expire;
    logic               resp_hs;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        tag_sel = req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
        accept  = (state_q == IDLE) && gnt_any;
        wd_max  = (wd_q == WD_LAST);
        // done in the final watchdog cycle still wins over expiry
        expire  = (state_q == WAIT) && !eng_done && wd_max;
        resp_hs = (state_q == RESP) && resp_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (gnt_any) state_d = START;
            START: state_d = WAIT;
            WAIT: begin
                if (eng_done)    state_d = RESP;
                else if (wd_max) state_d = IDLE;
            end
            RESP:  if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE && rst) ? gnt : '0;
        eng_start   = (state_q == START);
        resp_valid  = (state_q == RESP);
        busy        = (state_q != IDLE);
        eng_sel     = id_q;
        resp_id     = id_q;
        resp_tag    = tag_q;
        timeout_err = err_q;
    end

    always_comb begin
        id_d  = id_q;
        tag_d = tag_q;
        ptr_d = ptr_q;
        wd_d  = wd_q;
        err_d = err_q;
        if (accept) begin
            id_d  = gnt_idx;
            tag_d = tag_sel;
        end
        if (state_q == START) begin
            wd_d = '0;
        end else if (state_q == WAIT && !wd_max) begin
            wd_d = wd_q + 1'b1;
        end
        if (expire || resp_hs) begin
            ptr_d = id_q;
        end
        if (expire) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q  <= '0;
            tag_q <= '0;
            ptr_q <= ID_W'(N_REQ - 1);
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            id_q  <= id_d;
            tag_q <= tag_d;
            ptr_q <= ptr_d;
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_layernorm_sched.sv
// Directed bench for layernorm_sched: arbitration, backpressure,
// watchdog, stray/simultaneous done and mid-operation reset.
module tb_layernorm_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_tag;
    logic [3:0]  req_ready;
    logic        eng_start;
    logic [1:0]  eng_sel;
    logic        eng_done;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [3:0]  resp_tag;
    logic        resp_ready;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layernorm_sched #(
        .N_REQ   (4),
        .TAG_W   (4),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .eng_start   (eng_start),
        .eng_sel     (eng_sel),
        .eng_done    (eng_done),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_tag    (resp_tag),
        .resp_ready  (resp_ready),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req_valid  = '0;
        req_tag    = '0;
        eng_done   = 1'b0;
        resp_ready = 1'b0;
        err_clr    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        settle();
    endtask

    // From an IDLE cycle with a pending grant to id: run to RESP,
    // asserting eng_done d cycles after the start pulse.
    task automatic to_resp(input int id, input int d, input logic [3:0] tg);
        settle();
        check("grant", req_ready, 32'(1) << id);
        check("idle_busy", busy, 0);
        tick();
        check("start", eng_start, 1);
        check("sel", eng_sel, id);
        check("ready_low", req_ready, 0);
        repeat (d) tick();
        check("start_once", eng_start, 0);
        check("no_early_resp", resp_valid, 0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        settle();
        check("resp_v", resp_valid, 1);
        check("resp_id", resp_id, id);
        check("resp_tag", resp_tag, tg);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_start", eng_start, 0);
        check("rst_resp", resp_valid, 0);
        check("rst_err", timeout_err, 0);

        // single request from requester 2
        req_valid  = 4'b0100;
        req_tag    = 16'h0A00;
        resp_ready = 1'b1;
        to_resp(2, 5, 4'hA);
        req_valid = '0;
        tick();
        settle();
        check("single_idle", busy, 0);
        check("single_resp_gone", resp_valid, 0);

        // fairness: all requesters held valid
        do_reset();
        req_valid  = 4'hF;
        req_tag    = 16'h6543;
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            to_resp(k % 4, 3, 4'((k % 4) + 3));
            tick();
        end
        req_valid = '0;
        tick();

        // backpressure
        do_reset();
        req_valid  = 4'b0010;
        req_tag    = 16'h0050;
        resp_ready = 1'b0;
        to_resp(1, 2, 4'h5);
        req_valid = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            settle();
            check("bp_valid", resp_valid, 1);
            check("bp_id", resp_id, 1);
            check("bp_tag", resp_tag, 4'h5);
            check("bp_sel", eng_sel, 1);
            check("bp_ready", req_ready, 0);
            tick();
        end
        resp_ready = 1'b1;
        settle();
        check("bp_hs_valid", resp_valid, 1);
        tick();
        settle();
        check("bp_after", resp_valid, 0);
        check("bp_next_grant", req_ready, 4'b1000);
        req_valid  = '0;
        resp_ready = 1'b0;
        tick();

        // watchdog with a silent engine
        do_reset();
        req_valid = 4'b0100;
        req_tag   = 16'h0700;
        settle();
        check("wd_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("wd_start", eng_start, 1);
        tick();
        for (int k = 0; k < 8; k++) begin
            settle();
            check("wd_busy", busy, 1);
            check("wd_no_resp", resp_valid, 0);
            check("wd_err_low", timeout_err, 0);
            tick();
        end
        settle();
        check("wd_idle", busy, 0);
        check("wd_err", timeout_err, 1);
        check("wd_no_resp_end", resp_valid, 0);
        req_valid = 4'hF;
        settle();
        check("wd_next_grant", req_ready, 4'b1000);
        req_valid = '0;
        err_clr   = 1'b1;
        tick();
        err_clr = 1'b0;
        settle();
        check("wd_clr", timeout_err, 0);

        // stray done in IDLE
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        settle();
        check("stray_resp", resp_valid, 0);
        check("stray_busy", busy, 0);
        tick();
        check("stray_resp2", resp_valid, 0);

        // done in the last watchdog cycle
        req_valid = 4'b0001;
        req_tag   = 16'h0009;
        settle();
        check("sim_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        repeat (7) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        settle();
        check("sim_resp", resp_valid, 1);
        check("sim_err", timeout_err, 0);
        check("sim_id", resp_id, 0);
        check("sim_tag", resp_tag, 4'h9);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        settle();
        check("sim_idle", busy, 0);

        // reset while in WAIT
        req_valid = 4'b0010;
        req_tag   = 16'h00C0;
        settle();
        tick();
        req_valid = '0;
        tick();
        tick();
        check("mid_wait_busy", busy, 1);
        rst = 1'b0;
        settle();
        check("rw_busy", busy, 0);
        check("rw_start", eng_start, 0);
        check("rw_sel", eng_sel, 0);
        check("rw_resp", resp_valid, 0);
        check("rw_tag", resp_tag, 0);
        check("rw_ready", req_ready, 0);
        tick();
        rst       = 1'b1;
        req_valid = 4'hF;
        req_tag   = 16'h000D;
        settle();
        check("rw_first", req_ready, 4'b0001);

        // reset while in RESP
        tick();
        req_valid = '0;
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        settle();
        check("rr_in_resp", resp_valid, 1);
        check("rr_tag_pre", resp_tag, 4'hD);
        rst = 1'b0;
        settle();
        check("rr_resp", resp_valid, 0);
        check("rr_id", resp_id, 0);
        check("rr_tag", resp_tag, 0);
        check("rr_busy", busy, 0);
        tick();
        rst       = 1'b1;
        req_valid = 4'hF;
        settle();
        check("rr_first", req_ready, 4'b0001);
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
